// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N round-robin demux.
// Imported by the lane register and the top.
package demux_pkg;

  localparam int HOLD_PULSE  = 0;
  localparam int HOLD_STICKY = 1;

  localparam int LANES_MIN = 2;
  localparam int LANES_MAX = 16;

  function automatic int ptr_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One output lane: data register plus valid flag.
// Valid either pulses per write or sticks until reset.
module demux_lane_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic              we,
  input  logic              hold,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (we) data <= data_in;
      valid <= we | (hold & valid);
    end
  end

endmodule

// File: rtl/demux_1an_rr.sv
// Round-robin 1-to-LANES demux with sync realignment,
// per-round completion strobe and sticky misalignment flag.
module demux_1an_rr
  import demux_pkg::*;
#(
  parameter  int DATA_W    = 4,
  parameter  int LANES     = 2,
  parameter  int HOLD_MODE = HOLD_STICKY,
  localparam int PTR_W     = ptr_width(LANES)
) (
  input  logic                    clk_4f,
  input  logic                    reset_L,
  input  logic                    valid_in,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    sync_in,
  output logic [LANES*DATA_W-1:0] data_out,
  output logic [LANES-1:0]        valid_out,
  output logic                    group_valid,
  output logic [PTR_W-1:0]        lane_ptr,
  output logic                    err_misalign
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(LANES - 1);

  generate
    if (LANES < LANES_MIN || LANES > LANES_MAX) begin : g_bad_lanes
      $error("demux_1an_rr: LANES out of range");
    end
    if (HOLD_MODE != HOLD_PULSE && HOLD_MODE != HOLD_STICKY) begin : g_bad_hold
      $error("demux_1an_rr: illegal HOLD_MODE");
    end
  endgenerate

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nx;
  logic [PTR_W-1:0] target;
  logic [LANES-1:0] we;
  logic             hold_sticky;
  logic             gv_q;
  logic             err_q;

  assign target      = sync_in ? '0 : ptr;
  assign hold_sticky = (HOLD_MODE == HOLD_STICKY);

  // Explicit wrap keeps non-power-of-two LANES below LANES.
  always_comb begin
    ptr_nx = ptr;
    priority case (1'b1)
      valid_in: ptr_nx = (target == LAST) ? '0 : target + PTR_W'(1);
      sync_in:  ptr_nx = '0;
      default:  ptr_nx = ptr;
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      ptr   <= '0;
      gv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ptr   <= ptr_nx;
      gv_q  <= valid_in && (target == LAST);
      err_q <= err_q | (sync_in && (ptr != '0));
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign we[i] = valid_in && (target == PTR_W'(i));

      demux_lane_reg #(
        .DATA_W(DATA_W)
      ) u_lane (
        .clk_4f (clk_4f),
        .reset_L(reset_L),
        .we     (we[i]),
        .hold   (hold_sticky),
        .data_in(data_in),
        .data   (data_out[i*DATA_W +: DATA_W]),
        .valid  (valid_out[i])
      );
    end
  endgenerate

  assign group_valid  = gv_q;
  assign lane_ptr     = ptr;
  assign err_misalign = err_q;

endmodule

// File: tb/tb_demux_1an_rr.sv
// Bench for demux_1an_rr: three configurations on shared stimulus,
// directed tables, hand sequences and a random run against a model.
module tb_demux_1an_rr;

  logic       clk_4f = 1'b0;
  logic       reset_L;
  logic       valid_in;
  logic       sync_in;
  logic [7:0] data_in;

  logic [15:0] d4;
  logic [3:0]  v4;
  logic        gv4, e4;
  logic [1:0]  p4;
  logic [23:0] d3;
  logic [2:0]  v3;
  logic        gv3, e3;
  logic [1:0]  p3;
  logic [15:0] dh;
  logic [3:0]  vh;
  logic        gvh, eh;
  logic [1:0]  ph;

  always #5 clk_4f = ~clk_4f;

  demux_1an_rr #(.DATA_W(4), .LANES(4), .HOLD_MODE(0)) u4 (
    .clk_4f(clk_4f), .reset_L(reset_L), .valid_in(valid_in),
    .data_in(data_in[3:0]), .sync_in(sync_in), .data_out(d4),
    .valid_out(v4), .group_valid(gv4), .lane_ptr(p4),
    .err_misalign(e4)
  );

  demux_1an_rr #(.DATA_W(8), .LANES(3), .HOLD_MODE(0)) u3 (
    .clk_4f(clk_4f), .reset_L(reset_L), .valid_in(valid_in),
    .data_in(data_in), .sync_in(sync_in), .data_out(d3),
    .valid_out(v3), .group_valid(gv3), .lane_ptr(p3),
    .err_misalign(e3)
  );

  demux_1an_rr #(.DATA_W(4), .LANES(4), .HOLD_MODE(1)) uh (
    .clk_4f(clk_4f), .reset_L(reset_L), .valid_in(valid_in),
    .data_in(data_in[3:0]), .sync_in(sync_in), .data_out(dh),
    .valid_out(vh), .group_valid(gvh), .lane_ptr(ph),
    .err_misalign(eh)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: lanes as plain arrays, pointer as an int.
  int         m_lanes[3] = '{4, 3, 4};
  int         m_hold[3]  = '{0, 0, 1};
  int         m_w[3]     = '{4, 8, 4};
  int         m_ptr[3];
  logic [7:0] m_d[3][16];
  logic       m_v[3][16];
  logic       m_gv[3];
  logic       m_err[3];

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_ptr[c] = 0;
      m_gv[c]  = 1'b0;
      m_err[c] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        m_d[c][i] = '0;
        m_v[c][i] = 1'b0;
      end
    end
  endtask

  task automatic model_step(input logic v, input logic s,
                            input logic [7:0] d);
    for (int c = 0; c < 3; c++) begin
      int old;
      int t;
      logic [7:0] mask;
      old  = m_ptr[c];
      mask = 8'((1 << m_w[c]) - 1);
      m_gv[c] = 1'b0;
      if (m_hold[c] == 0)
        for (int i = 0; i < 16; i++) m_v[c][i] = 1'b0;
      if (v) begin
        t = s ? 0 : old;
        m_d[c][t] = d & mask;
        m_v[c][t] = 1'b1;
        m_gv[c]   = (t == m_lanes[c] - 1);
        m_ptr[c]  = (t + 1) % m_lanes[c];
      end else if (s) begin
        m_ptr[c] = 0;
      end
      if (s && old != 0) m_err[c] = 1'b1;
    end
  endtask

  function automatic logic [63:0] exp_data(input int c);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < m_lanes[c]; i++)
      r = r | (64'(m_d[c][i]) << (i * m_w[c]));
    return r;
  endfunction

  function automatic logic [63:0] exp_valid(input int c);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < m_lanes[c]; i++)
      r[i] = m_v[c][i];
    return r;
  endfunction

  task automatic compare_all();
    check("l4_data",  64'(d4),  exp_data(0));
    check("l4_valid", 64'(v4),  exp_valid(0));
    check("l4_gv",    64'(gv4), 64'(m_gv[0]));
    check("l4_ptr",   64'(p4),  64'(m_ptr[0]));
    check("l4_err",   64'(e4),  64'(m_err[0]));
    check("l3_data",  64'(d3),  exp_data(1));
    check("l3_valid", 64'(v3),  exp_valid(1));
    check("l3_gv",    64'(gv3), 64'(m_gv[1]));
    check("l3_ptr",   64'(p3),  64'(m_ptr[1]));
    check("l3_err",   64'(e3),  64'(m_err[1]));
    check("l3_ptr_range", 64'(p3 < 2'd3), 64'(1));
    check("h4_data",  64'(dh),  exp_data(2));
    check("h4_valid", 64'(vh),  exp_valid(2));
    check("h4_gv",    64'(gvh), 64'(m_gv[2]));
    check("h4_ptr",   64'(ph),  64'(m_ptr[2]));
    check("h4_err",   64'(eh),  64'(m_err[2]));
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    valid_in = v;
    sync_in  = s;
    data_in  = d;
    @(posedge clk_4f);
    model_step(v, s, d);
    #1;
    compare_all();
    valid_in = 1'b0;
    sync_in  = 1'b0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk_4f);
    reset_L = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic [15:0] exp_d;
    logic [1:0]  exp_p;
    logic        exp_gv;
    logic        exp_e;
  } vec_t;

  vec_t tbl[10];

  initial begin
    reset_L  = 1'b1;
    valid_in = 1'b0;
    sync_in  = 1'b0;
    data_in  = '0;
    #2;
    do_reset();

    // Fill four lanes, then a sync collision at ptr=2.
    tbl[0] = '{1, 0, 8'h1, 16'h0001, 2'd1, 0, 0};
    tbl[1] = '{1, 0, 8'h2, 16'h0021, 2'd2, 0, 0};
    tbl[2] = '{1, 0, 8'h3, 16'h0321, 2'd3, 0, 0};
    tbl[3] = '{1, 0, 8'h4, 16'h4321, 2'd0, 1, 0};
    tbl[4] = '{0, 0, 8'h0, 16'h4321, 2'd0, 0, 0};
    tbl[5] = '{1, 0, 8'h5, 16'h4325, 2'd1, 0, 0};
    tbl[6] = '{1, 0, 8'h6, 16'h4365, 2'd2, 0, 0};
    tbl[7] = '{1, 1, 8'h7, 16'h4367, 2'd1, 0, 1};
    tbl[8] = '{0, 0, 8'h0, 16'h4367, 2'd1, 0, 1};
    tbl[9] = '{0, 1, 8'h0, 16'h4367, 2'd0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("tbl%0d_data", i), 64'(d4), 64'(tbl[i].exp_d));
      check($sformatf("tbl%0d_ptr", i), 64'(p4), 64'(tbl[i].exp_p));
      check($sformatf("tbl%0d_gv", i), 64'(gv4), 64'(tbl[i].exp_gv));
      check($sformatf("tbl%0d_err", i), 64'(e4), 64'(tbl[i].exp_e));
    end
    do_reset();
    check("err_cleared", 64'(e4), 64'(0));

    // Three lanes, seven words 0xA..0x10.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 8'(8'h0A + i));
      if (i == 5) check("l3_sixth", 64'(d3), 64'h0F0E0D);
    end
    check("l3_seventh", 64'(d3), 64'h0F0E10);
    check("l3_ptr_after7", 64'(p3), 64'(1));

    // Gapped input: pulse vs sticky valid.
    do_reset();
    step(1'b1, 1'b0, 8'h5);
    check("gap_v0", 64'(v4), 64'b0001);
    step(1'b0, 1'b0, 8'h0);
    check("gap_idle_v", 64'(v4), 64'b0000);
    check("gap_idle_d", 64'(d4), 64'h0005);
    step(1'b1, 1'b0, 8'h6);
    check("gap_v1", 64'(v4), 64'b0010);
    check("gap_sticky", 64'(vh), 64'b0011);

    // Sticky valid across 20 idle cycles.
    do_reset();
    step(1'b1, 1'b0, 8'h9);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 8'h0);
      check("hold_v", 64'(vh), 64'b0001);
      check("hold_d", 64'(dh), 64'h0009);
    end

    // Reset between edges mid-round.
    do_reset();
    step(1'b1, 1'b0, 8'hA);
    step(1'b1, 1'b0, 8'hB);
    #3;
    reset_L = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("async_d4", 64'(d4), 64'(0));
    check("async_p4", 64'(p4), 64'(0));
    @(negedge clk_4f);
    reset_L = 1'b1;
    step(1'b1, 1'b0, 8'hC);
    check("post_rst_d4", 64'(d4), 64'h000C);
    check("post_rst_p4", 64'(p4), 64'(1));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
           8'($urandom));
      if (i == 200) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
